udp_packet_builder: RTL and testbench
=====================================

# udp_packet_builder

Transmit-side counterpart of the UDP parser: serialises an 8-byte UDP header (source port, destination port, length, checksum) followed by a byte-wide payload into a single valid/ready byte stream. A packet is started with a one-cycle `start` pulse carrying the header fields. Payload bytes are pulled from an upstream source. The output stream is byte-for-byte what the parser consumes, so the two blocks can be looped back directly.

## Interface
Parameters:
- MAX_PAYLOAD, 1472: largest accepted `payload_len` in bytes; must be ≤ 65527.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to build a packet; sampled only in IDLE.
- src_port  in  16  source port; latched on accepted `start`.
- dst_port  in  16  destination port; latched on accepted `start`.
- payload_len  in  16  payload byte count; latched on accepted `start`.
- payload_data_in  in  8  payload byte from upstream.
- payload_valid_in  in  1  upstream byte valid.
- payload_last_in  in  1  marks final upstream byte. Used only with UDP_BUILDER_LEN_CHECK_EN.
- payload_ready_out  out  1  builder accepts a payload byte this cycle.
- data_out  out  8  serialised packet byte.
- data_valid_out  out  1  `data_out` valid.
- data_last_out  out  1  final byte of packet, qualified by `data_valid_out`.
- data_ready_in  in  1  downstream accepts `data_out`.
- busy  out  1  packet in progress.
- done  out  1  one-cycle pulse after the final byte handshake.
- len_err  out  1  one-cycle pulse on a length fault.

## Operation
- States: IDLE, HEADER, PAYLOAD, DRAIN (DRAIN exists only with the macro).
- IDLE:
  - If `start`=1 and `payload_len` ≤ MAX_PAYLOAD: latch the fields, clear the byte index, go to HEADER.
  - If `payload_len` > MAX_PAYLOAD: pulse `len_err` and stay in IDLE.
- HEADER: emit bytes 0..7, big-endian: src[15:8], src[7:0], dst[15:8], dst[7:0], len[15:8], len[7:0], 8'h00, 8'h00.
  - len = payload_len + 8, 16-bit, no overflow given the MAX_PAYLOAD bound.
  - Checksum is always 0.
  - After byte 7 is handshaken: go to PAYLOAD, or to IDLE if payload_len = 0. In that case byte 7 carries `data_last_out`.
- PAYLOAD: pass upstream bytes through, counting them.
  - The byte where count = payload_len−1 carries `data_last_out`.
  - After its handshake, return to IDLE.
- Output register rule: loaded when empty, or when consumed in the same cycle (`!data_valid_out || data_ready_in`).
- `payload_ready_out` = PAYLOAD && output register free by the rule above. It is combinational from state and `data_ready_in`.
- `start` outside IDLE is ignored; no queuing.
- Upstream bytes offered outside PAYLOAD are not accepted.

## Timing
- Reset values: `data_out`=0, `data_valid_out`=0, `data_last_out`=0, `payload_ready_out`=0, `busy`=0, `done`=0, `len_err`=0; state IDLE.
- Latency: `start` sampled at edge N; header byte 0 is valid after edge N+1.
- `busy` is high from edge N+1 until the final handshake edge.
- Throughput: 1 byte/cycle with `data_ready_in` held high and upstream never stalling.
- `data_out`/`data_last_out` hold stable while `data_valid_out`=1 and `data_ready_in`=0.
- `done` is high for the one cycle after the final handshake edge. `busy` is 0 in that cycle, and a new `start` is accepted in it.
- Upstream stall (`payload_valid_in`=0): `data_valid_out` drops once the register drains; no bubble byte is emitted.
- Reset mid-packet: all outputs are cleared immediately. The partial packet is abandoned, not resumed.

## Configuration
- UDP_BUILDER_LEN_CHECK_EN defined: `payload_last_in` is checked against `payload_len`.
  - Early last (count < payload_len−1): pulse `len_err`, then pad the remaining bytes with 8'h00 without asserting `payload_ready_out`. The packet stays exactly payload_len+8 bytes.
  - Late or missing last at count = payload_len−1: emit that byte with `data_last_out`, pulse `len_err`, then go to DRAIN.
  - DRAIN: `payload_ready_out`=1 and upstream bytes are discarded (nothing emitted) up to and including the one with `payload_last_in`; then go to IDLE.
  - `done` fires after the final output handshake. `busy` stays high through DRAIN.
- Not defined: `payload_last_in` is ignored, exactly payload_len bytes are taken, and the DRAIN state and padding logic are absent. `len_err` fires only for MAX_PAYLOAD violations.

## Structure
- Shared package `udp_pkg`:
  - UDP_HDR_BYTES = 8.
  - Header struct {src_port, dst_port, length, checksum}.
  - Builder state enum.
  - The parser uses the same package.
- One sub-module `udp_tx_out_reg`: a single-entry output register implementing the load rule and the stable-while-stalled guarantee.

## Test plan
- Reset, then `start` with src 49152, dst 1234, len 9; payload "TEST TEST"; `data_ready_in`=1.
  - Expected: C0 00 04 D2 00 11 00 00 54 45 53 54 20 54 45 53 54, 17 consecutive cycles.
  - `data_last_out` on the final 54; `done` one cycle later.
- Same packet with `data_ready_in` toggling 1-0-1-0.
  - Expected: identical byte sequence, `data_out` stable during every stall, no duplicated bytes.
- `payload_len`=0.
  - Expected: 8 header bytes with length 00 08, `data_last_out` on byte 7.
  - `payload_ready_out` never asserts.
- `payload_len`=1500 with MAX_PAYLOAD=1472.
  - Expected: `len_err` pulse, `busy` stays 0, no output.
- With the macro, len 9, upstream asserts last on byte 5.
  - Expected: `len_err`, then bytes 6–9 emitted as 00, total 17 bytes.
- Reset asserted during header byte 3.
  - Expected: outputs 0 immediately.
  - A following `start` yields a complete, correct packet.

Source files
------------

// File: rtl/udp_pkg.sv
// Shared UDP definitions used by the packet builder and the parser.
package udp_pkg;

  localparam int UDP_HDR_BYTES = 8;

  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] length;
    logic [15:0] checksum;
  } udp_hdr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_DRAIN
  } bld_state_t;

  // Header byte i on the wire (big-endian, byte 0 = src_port[15:8]).
  function automatic logic [7:0] hdr_byte(udp_hdr_t h, logic [2:0] i);
    logic [63:0] f;
    f = h;
    f = f << {i, 3'b000};
    return f[63:56];
  endfunction

endpackage

// File: rtl/udp_packet_builder_if.sv
// Payload-in and packet-out byte streams of the UDP packet builder.
interface udp_packet_builder_if;
  logic [7:0] payload_data_in;
  logic       payload_valid_in;
  logic       payload_last_in;
  logic       payload_ready_out;
  logic [7:0] data_out;
  logic       data_valid_out;
  logic       data_last_out;
  logic       data_ready_in;

  modport master (
    input  payload_data_in, payload_valid_in, payload_last_in, data_ready_in,
    output payload_ready_out, data_out, data_valid_out, data_last_out
  );

  modport slave (
    output payload_data_in, payload_valid_in, payload_last_in, data_ready_in,
    input  payload_ready_out, data_out, data_valid_out, data_last_out
  );
endinterface

// File: rtl/udp_tx_out_reg.sv
// Single-entry output register: loads when empty or drained this cycle,
// otherwise holds data/last stable while downstream stalls.
module udp_tx_out_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  input  logic       load_last,
  input  logic       ready,
  output logic       free,
  output logic [7:0] data,
  output logic       valid,
  output logic       last
);

  assign free = !valid || ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= 8'h00;
      last  <= 1'b0;
    end else if (free) begin
      valid <= load_valid;
      if (load_valid) begin
        data <= load_data;
        last <= load_last;
      end
    end
  end

endmodule

// File: rtl/udp_packet_builder.sv
// UDP packet builder: 8-byte header then payload as one valid/ready byte stream.
// Optional UDP_BUILDER_LEN_CHECK_EN checks payload_last_in against payload_len.
module udp_packet_builder
  import udp_pkg::*;
#(
  parameter int MAX_PAYLOAD = 1472
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [15:0]          src_port,
  input  logic [15:0]          dst_port,
  input  logic [15:0]          payload_len,
  udp_packet_builder_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 len_err
);

  localparam logic [15:0] MAX_LEN  = 16'(MAX_PAYLOAD);
  localparam logic [15:0] HDR_LAST = 16'(UDP_HDR_BYTES - 1);

  bld_state_t  state, nxt;
  udp_hdr_t    hdr, hdr_n;
  logic [15:0] plen, plen_n;
  logic [15:0] idx, idx_n;
  logic        fin, fin_n;
  logic        len_err_n;
  logic        free, ld_v, ld_l, pr;
  logic [7:0]  ld_d;
  logic        hs_last, pay_last;
`ifdef UDP_BUILDER_LEN_CHECK_EN
  logic        pad, pad_n;
  logic        drained, drained_n;
`else
  logic        unused_last;
  assign unused_last = bus.payload_last_in;
`endif

  // fin: the final byte is in the output register, waiting for its handshake.
  assign hs_last  = bus.data_valid_out && bus.data_ready_in && bus.data_last_out;
  assign pay_last = (idx == plen - 16'd1);
  assign busy     = (state != ST_IDLE);
  assign bus.payload_ready_out = pr;

  always_comb begin
    nxt       = state;
    hdr_n     = hdr;
    plen_n    = plen;
    idx_n     = idx;
    fin_n     = fin && !hs_last;
    len_err_n = 1'b0;
    ld_v      = 1'b0;
    ld_d      = 8'h00;
    ld_l      = 1'b0;
    pr        = 1'b0;
`ifdef UDP_BUILDER_LEN_CHECK_EN
    pad_n     = pad;
    drained_n = drained;
`endif
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (payload_len > MAX_LEN) begin
            len_err_n = 1'b1;
          end else begin
            hdr_n  = '{src_port, dst_port, payload_len + 16'd8, 16'h0000};
            plen_n = payload_len;
            idx_n  = 16'd0;
            fin_n  = 1'b0;
`ifdef UDP_BUILDER_LEN_CHECK_EN
            pad_n  = 1'b0;
`endif
            nxt    = ST_HEADER;
          end
        end
      end
      ST_HEADER: begin
        if (!fin && free) begin
          ld_v = 1'b1;
          ld_d = hdr_byte(hdr, idx[2:0]);
          ld_l = (idx == HDR_LAST) && (plen == 16'd0);
          if (idx == HDR_LAST) begin
            idx_n = 16'd0;
            if (plen == 16'd0) fin_n = 1'b1;
            else               nxt   = ST_PAYLOAD;
          end else begin
            idx_n = idx + 16'd1;
          end
        end
        if (fin && hs_last) nxt = ST_IDLE;
      end
      ST_PAYLOAD: begin
`ifdef UDP_BUILDER_LEN_CHECK_EN
        pr = !fin && !pad && free;
`else
        pr = !fin && free;
`endif
        if (pr && bus.payload_valid_in) begin
          ld_v = 1'b1;
          ld_d = bus.payload_data_in;
          ld_l = pay_last;
          if (pay_last) fin_n = 1'b1;
          else          idx_n = idx + 16'd1;
`ifdef UDP_BUILDER_LEN_CHECK_EN
          if (pay_last && !bus.payload_last_in) begin
            len_err_n = 1'b1;
            drained_n = 1'b0;
            nxt       = ST_DRAIN;
          end else if (!pay_last && bus.payload_last_in) begin
            len_err_n = 1'b1;
            pad_n     = 1'b1;
          end
        end else if (pad && !fin && free) begin
          // upstream ended early: zero-fill to the advertised length
          ld_v = 1'b1;
          ld_l = pay_last;
          if (pay_last) fin_n = 1'b1;
          else          idx_n = idx + 16'd1;
`endif
        end
        if (fin && hs_last) nxt = ST_IDLE;
      end
`ifdef UDP_BUILDER_LEN_CHECK_EN
      ST_DRAIN: begin
        pr = !drained;
        if (pr && bus.payload_valid_in && bus.payload_last_in) drained_n = 1'b1;
        if (drained_n && !fin_n) nxt = ST_IDLE;
      end
`endif
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      hdr     <= '0;
      plen    <= 16'd0;
      idx     <= 16'd0;
      fin     <= 1'b0;
      done    <= 1'b0;
      len_err <= 1'b0;
`ifdef UDP_BUILDER_LEN_CHECK_EN
      pad     <= 1'b0;
      drained <= 1'b0;
`endif
    end else begin
      state   <= nxt;
      hdr     <= hdr_n;
      plen    <= plen_n;
      idx     <= idx_n;
      fin     <= fin_n;
      done    <= hs_last;
      len_err <= len_err_n;
`ifdef UDP_BUILDER_LEN_CHECK_EN
      pad     <= pad_n;
      drained <= drained_n;
`endif
    end
  end

  udp_tx_out_reg u_out (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (ld_v),
    .load_data  (ld_d),
    .load_last  (ld_l),
    .ready      (bus.data_ready_in),
    .free       (free),
    .data       (bus.data_out),
    .valid      (bus.data_valid_out),
    .last       (bus.data_last_out)
  );

endmodule

// File: tb/tb_udp_packet_builder.sv
// Randomised self-checking bench for udp_packet_builder against a byte-queue packet model.
module tb_udp_packet_builder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] src_port = '0, dst_port = '0, payload_len = '0;
  logic        busy, done, len_err;

  udp_packet_builder_if bus();

  udp_packet_builder #(.MAX_PAYLOAD(1472)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_port(src_port),
    .dst_port(dst_port), .payload_len(payload_len), .bus(bus),
    .busy(busy), .done(done), .len_err(len_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  byte unsigned pl[$], exp_q[$], got[$];
  bit  got_last[$];
  int  got_cyc[$];
  int  stall_viol, pready_cnt, lenerr_cnt, busy_cnt, done_cyc, cyc;
  bit  finished, busy_at_done;

  // Reference packet: header fields big-endian, length = payload + 8, checksum 0.
  task automatic build_exp(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
    logic [15:0] ln;
    ln = l + 16'd8;
    exp_q = '{s[15:8], s[7:0], d[15:8], d[7:0], ln[15:8], ln[7:0], 8'h00, 8'h00};
    foreach (pl[i]) exp_q.push_back(pl[i]);
  endtask

  function automatic int diff_idx();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= got.size()) return i;
      if (got[i] != exp_q[i] || got_last[i] != (i == exp_q.size() - 1)) return i;
    end
    if (got.size() != exp_q.size()) return exp_q.size();
    return -1;
  endfunction

  // Drives one packet; rmode 0 ready=1, 1 toggling, 2 random; vmode 1 = random upstream gaps.
  task automatic run_pkt(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                         input int rmode, input int vmode, input int budget, input bit now);
    int pi;
    bit r, held, hl;
    byte unsigned hd;
    got.delete(); got_last.delete(); got_cyc.delete();
    stall_viol = 0; pready_cnt = 0; lenerr_cnt = 0; busy_cnt = 0;
    done_cyc = -1; finished = 0; busy_at_done = 1; held = 0; hd = 0; hl = 0; pi = 0;
    if (!now) @(negedge clk);
    start = 1; src_port = s; dst_port = d; payload_len = l;
    @(negedge clk);
    start = 0; src_port = 16'($urandom); dst_port = 16'($urandom); payload_len = 16'($urandom);
    cyc = 0;
    while (!finished && cyc < budget) begin
      case (rmode)
        0:       r = 1'b1;
        1:       r = (cyc % 2 == 0);
        default: r = ($urandom_range(0, 3) != 0);
      endcase
      bus.data_ready_in    = r;
      bus.payload_valid_in = (pi < pl.size()) && (vmode == 0 || $urandom_range(0, 2) != 0);
      bus.payload_data_in  = (pi < pl.size()) ? pl[pi] : 8'($urandom);
      bus.payload_last_in  = (pi == int'(pl.size()) - 1);
      #1;
      if (busy) busy_cnt++;
      if (len_err) lenerr_cnt++;
      if (bus.payload_ready_out) pready_cnt++;
      if (bus.payload_ready_out && bus.payload_valid_in) pi++;
      if (bus.data_valid_out) begin
        if (held && (bus.data_out !== hd || bus.data_last_out !== hl)) stall_viol++;
        if (r) begin
          got.push_back(bus.data_out); got_last.push_back(bus.data_last_out);
          got_cyc.push_back(cyc); held = 0;
        end else begin
          held = 1; hd = bus.data_out; hl = bus.data_last_out;
        end
      end else begin
        if (held) stall_viol++;
        held = 0;
      end
      if (done) begin
        finished = 1; done_cyc = cyc; busy_at_done = busy;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    bus.payload_valid_in = 0;
  endtask

  task automatic test_reset();
    bus.data_ready_in = 0; bus.payload_valid_in = 0; bus.payload_last_in = 0; bus.payload_data_in = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({bus.data_out, bus.data_valid_out, bus.data_last_out, bus.payload_ready_out, done, len_err} !== 13'd0)
      $display("FAIL reset_outputs got=%h want=0",
               {bus.data_out, bus.data_valid_out, bus.data_last_out, bus.payload_ready_out, done, len_err});
    else n_pass++;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else n_pass++;
    rst_n = 1;
  endtask

  task automatic test_basic();
    int di;
    pl = '{8'h54, 8'h45, 8'h53, 8'h54, 8'h20, 8'h54, 8'h45, 8'h53, 8'h54};
    build_exp(16'd49152, 16'd1234, 16'd9);
    run_pkt(16'd49152, 16'd1234, 16'd9, 0, 0, 60, 0);
    di = diff_idx();
    n_chk++;
    if (di != -1) $display("FAIL basic_bytes first_bad=%0d got_n=%0d want_n=%0d", di, got.size(), exp_q.size());
    else n_pass++;
    n_chk++;
    if (got_cyc.size() != 17 || got_cyc[0] != 1 || got_cyc[16] != 17)
      $display("FAIL basic_timing got_n=%0d first=%0d want 17 bytes at cycles 1..17", got_cyc.size(),
               got_cyc.size() > 0 ? got_cyc[0] : -1);
    else n_pass++;
    n_chk++;
    if (done_cyc != 18) $display("FAIL basic_done got_cycle=%0d want=18", done_cyc); else n_pass++;
    n_chk++;
    if (busy_at_done !== 1'b0) $display("FAIL basic_busy_at_done got=%b want=0", busy_at_done); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int di;
    pl.delete();
    for (int i = 0; i < 4; i++) pl.push_back(8'($urandom));
    build_exp(16'h1111, 16'h2222, 16'd4);
    run_pkt(16'h1111, 16'h2222, 16'd4, 0, 0, 40, 1);
    di = diff_idx();
    n_chk++;
    if (di != -1 || done_cyc != 13)
      $display("FAIL back_to_back first_bad=%0d done_cycle=%0d want -1/13", di, done_cyc);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int di;
    pl = '{8'h54, 8'h45, 8'h53, 8'h54, 8'h20, 8'h54, 8'h45, 8'h53, 8'h54};
    build_exp(16'd49152, 16'd1234, 16'd9);
    run_pkt(16'd49152, 16'd1234, 16'd9, 1, 0, 100, 0);
    di = diff_idx();
    n_chk++;
    if (di != -1) $display("FAIL bp_bytes first_bad=%0d got_n=%0d want_n=%0d", di, got.size(), exp_q.size());
    else n_pass++;
    n_chk++;
    if (stall_viol != 0) $display("FAIL bp_stable got=%0d violations want=0", stall_viol); else n_pass++;
    n_chk++;
    if (!finished) $display("FAIL bp_done got=no_done want=done"); else n_pass++;
  endtask

  task automatic test_zero_len();
    int di;
    logic [15:0] s, d;
    s = 16'($urandom); d = 16'($urandom);
    pl.delete();
    build_exp(s, d, 16'd0);
    run_pkt(s, d, 16'd0, 0, 0, 40, 0);
    di = diff_idx();
    n_chk++;
    if (di != -1) $display("FAIL zero_len_bytes first_bad=%0d got_n=%0d want_n=8", di, got.size());
    else n_pass++;
    n_chk++;
    if (pready_cnt != 0) $display("FAIL zero_len_pready got=%0d want=0", pready_cnt); else n_pass++;
  endtask

  task automatic test_len_err();
    pl.delete();
    run_pkt(16'd7, 16'd8, 16'd1500, 0, 0, 10, 0);
    n_chk++;
    if (lenerr_cnt != 1) $display("FAIL len_err_pulse got=%0d want=1", lenerr_cnt); else n_pass++;
    n_chk++;
    if (busy_cnt != 0 || got.size() != 0)
      $display("FAIL len_err_idle got busy=%0d bytes=%0d want 0/0", busy_cnt, got.size());
    else n_pass++;
  endtask

  task automatic test_random();
    int di, l;
    logic [15:0] s, d;
    for (int k = 0; k < 8; k++) begin
      l = $urandom_range(0, 40);
      s = 16'($urandom); d = 16'($urandom);
      pl.delete();
      for (int i = 0; i < l; i++) pl.push_back(8'($urandom));
      build_exp(s, d, 16'(l));
      run_pkt(s, d, 16'(l), 2, 1, 600, 0);
      di = diff_idx();
      n_chk++;
      if (di != -1 || stall_viol != 0 || !finished)
        $display("FAIL random_pkt%0d len=%0d first_bad=%0d viol=%0d done=%0b want -1/0/1",
                 k, l, di, stall_viol, finished);
      else n_pass++;
    end
  endtask

  task automatic test_midreset();
    int di;
    pl.delete();
    pl = '{8'hA1, 8'hB2, 8'hC3};
    build_exp(16'hBEEF, 16'hCAFE, 16'd3);
    @(negedge clk);
    start = 1; src_port = 16'hBEEF; dst_port = 16'hCAFE; payload_len = 16'd3;
    bus.data_ready_in = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    #1;
    n_chk++;
    if (bus.data_valid_out !== 1'b1 || bus.data_out !== exp_q[3])
      $display("FAIL midreset_byte3 got=%h v=%b want=%h v=1", bus.data_out, bus.data_valid_out, exp_q[3]);
    else n_pass++;
    rst_n = 0;
    #1;
    n_chk++;
    if ({bus.data_out, bus.data_valid_out, bus.data_last_out, bus.payload_ready_out, busy, done, len_err} !== 14'd0)
      $display("FAIL midreset_clear got=%h want=0",
               {bus.data_out, bus.data_valid_out, bus.data_last_out, bus.payload_ready_out, busy, done, len_err});
    else n_pass++;
    @(negedge clk);
    rst_n = 1;
    pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    build_exp(16'd80, 16'd443, 16'd5);
    run_pkt(16'd80, 16'd443, 16'd5, 2, 1, 200, 0);
    di = diff_idx();
    n_chk++;
    if (di != -1 || !finished) $display("FAIL midreset_after first_bad=%0d done=%0b want -1/1", di, finished);
    else n_pass++;
  endtask

`ifdef UDP_BUILDER_LEN_CHECK_EN
  task automatic test_early_last();
    int di;
    pl.delete();
    for (int i = 0; i < 5; i++) pl.push_back(8'($urandom_range(1, 255)));
    build_exp(16'd100, 16'd200, 16'd9);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
    run_pkt(16'd100, 16'd200, 16'd9, 0, 0, 60, 0);
    di = diff_idx();
    n_chk++;
    if (di != -1) $display("FAIL early_last_bytes first_bad=%0d got_n=%0d want_n=17", di, got.size());
    else n_pass++;
    n_chk++;
    if (lenerr_cnt != 1) $display("FAIL early_last_len_err got=%0d want=1", lenerr_cnt); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_zero_len();
    test_len_err();
    test_random();
    test_midreset();
`ifdef UDP_BUILDER_LEN_CHECK_EN
    test_early_last();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
